// File: rtl/omok_board_engine.sv
// Parametrised Omok board: alternating stone placement with an undo stack and a
// sequential k-in-a-row scan run after each accepted placement.
module omok_board_engine #(
  parameter int MAP_N      = 10,
  parameter int WIN_LEN    = 5,
  parameter int HIST_DEPTH = 100,
  parameter int POS_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [POS_W-1:0]       cur_pos,
  input  logic                   put,
  input  logic                   undo,
  output logic [MAP_N*MAP_N-1:0] board_state,
  output logic [MAP_N*MAP_N-1:0] turn_map,
  output logic                   next_color,
  output logic [POS_W:0]         move_count,
  output logic                   busy,
  output logic                   game_over,
  output logic                   winner,
  output logic                   rejected
);

  localparam int CELLS = MAP_N * MAP_N;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int HW    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int RC_W  = $clog2(MAP_N) + 2;
  localparam int RUN_W = $clog2(WIN_LEN + 1) + 1;

  localparam logic [POS_W:0]          CELLS_C   = (POS_W+1)'(CELLS);
  localparam logic [POS_W:0]          HIST_FULL = (POS_W+1)'(HIST_DEPTH);
  localparam logic [POS_W:0]          SP_ONE    = (POS_W+1)'(1);
  localparam logic signed [RC_W-1:0]  N_S       = RC_W'(MAP_N);
  localparam logic signed [RC_W-1:0]  C_ONE     = RC_W'(1);
  localparam logic signed [RC_W-1:0]  C_ZERO    = '0;
  localparam logic [RUN_W-1:0]        RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]        WIN_C     = RUN_W'(WIN_LEN);
  localparam logic [RUN_W-1:0]        STEP_MAX  = RUN_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state, state_n;
  logic                    put_q, undo_q;
  logic [POS_W:0]          sp;
  logic [IDX_W-1:0]        hist [HIST_DEPTH];
  logic signed [RC_W-1:0]  org_r, org_c, cr, cc;
  logic                    scan_color;
  logic [1:0]              dir;
  logic                    side;
  logic [RUN_W-1:0]        steps, run;
  logic                    win;

  // Request qualification
  logic                    put_edge, undo_edge, idle;
  logic [IDX_W-1:0]        cur_idx, top_idx;
  logic [POS_W:0]          sp_m1;
  logic                    pos_valid, put_ok, do_put, put_rej, do_undo, undo_rej;
  logic signed [RC_W-1:0]  row0, col0;

  assign put_edge  = put & ~put_q;
  assign undo_edge = undo & ~undo_q;
  assign idle      = (state == IDLE);
  assign cur_idx   = cur_pos[IDX_W-1:0];
  assign pos_valid = ({1'b0, cur_pos} < CELLS_C);
  assign sp_m1     = sp - SP_ONE;
  assign top_idx   = hist[sp_m1[HW-1:0]];
  assign put_ok    = !game_over && pos_valid && !board_state[cur_idx] && (sp != HIST_FULL);
  assign do_put    = idle && put_edge && !undo_edge && put_ok;
  assign put_rej   = idle && put_edge && !undo_edge && !put_ok;
  assign do_undo   = idle && undo_edge && (sp != '0);
  assign undo_rej  = idle && undo_edge && (sp == '0);
  assign row0      = RC_W'(int'(cur_idx) / MAP_N);
  assign col0      = RC_W'(int'(cur_idx) % MAP_N);
  assign move_count = sp;

  // Scan step: one neighbour per cycle along direction dir, side selects +/-
  logic signed [RC_W-1:0]  dr, dc, nr, nc;
  logic                    in_bounds, match, step_win;
  logic [IDX_W-1:0]        nidx;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    dr = C_ZERO;
    dc = C_ZERO;
    case (dir)
      2'd0:    dc = C_ONE;
      2'd1:    dr = C_ONE;
      2'd2:    begin dr = C_ONE; dc = C_ONE; end
      default: begin dr = C_ONE; dc = -C_ONE; end
    endcase
    if (side) begin
      dr = -dr;
      dc = -dc;
    end
  end

  assign nr        = cr + dr;
  assign nc        = cc + dc;
  assign in_bounds = (nr >= C_ZERO) && (nr < N_S) && (nc >= C_ZERO) && (nc < N_S);
  assign nidx      = IDX_W'(int'(nr) * MAP_N + int'(nc));
  assign match     = in_bounds && board_state[nidx] && (turn_map[nidx] == scan_color)
                     && (steps < STEP_MAX);
  assign step_win  = match && ((run + RUN_ONE) >= WIN_C);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (do_put) state_n = SCAN;
      SCAN:    if (step_win || (!match && side && dir == 2'd3)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: the history memory has no reset; entries above the stack pointer are never read.
  always_ff @(posedge clk) begin
    if (do_put) hist[sp[HW-1:0]] <= cur_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_state <= '0;
      turn_map    <= '0;
      sp          <= '0;
      next_color  <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      rejected    <= 1'b0;
      put_q       <= 1'b0;
      undo_q      <= 1'b0;
      org_r       <= '0;
      org_c       <= '0;
      cr          <= '0;
      cc          <= '0;
      scan_color  <= 1'b0;
      dir         <= '0;
      side        <= 1'b0;
      steps       <= '0;
      run         <= '0;
      win         <= 1'b0;
    end else begin
      put_q    <= put;
      undo_q   <= undo;
      rejected <= put_rej | undo_rej;

      if (do_put) begin
        board_state[cur_idx] <= 1'b1;
        turn_map[cur_idx]    <= next_color;
        sp         <= sp + SP_ONE;
        next_color <= ~next_color;
        busy       <= 1'b1;
        org_r      <= row0;
        org_c      <= col0;
        cr         <= row0;
        cc         <= col0;
        scan_color <= next_color;
        dir        <= '0;
        side       <= 1'b0;
        steps      <= '0;
        run        <= RUN_ONE;
        win        <= 1'b0;
      end else if (do_undo) begin
        board_state[top_idx] <= 1'b0;
        turn_map[top_idx]    <= 1'b0;
        sp         <= sp_m1;
        next_color <= ~next_color;
        game_over  <= 1'b0;
        winner     <= 1'b0;
      end

      if (state == SCAN) begin
        if (match) begin
          cr    <= nr;
          cc    <= nc;
          steps <= steps + RUN_ONE;
          run   <= run + RUN_ONE;
          if (step_win) win <= 1'b1;
        end else begin
          // Side finished: restart from the origin on the other side or next direction
          cr    <= org_r;
          cc    <= org_c;
          steps <= '0;
          side  <= ~side;
          if (side) dir <= dir + 2'd1;
        end
      end

      if (state == DONE) begin
        busy      <= 1'b0;
        game_over <= win;
        winner    <= scan_color;
      end
    end
  end

endmodule

// File: tb/tb_omok_board_engine.sv
// Self-checking bench for omok_board_engine: reference board model plus a
// scoreboard of expected outputs per request.
module tb_omok_board_engine;

  localparam int N     = 10;
  localparam int CELLS = N * N;

  logic             clk = 1'b0;
  logic             rst, put, undo;
  logic [7:0]       cur_pos;
  logic [CELLS-1:0] board_state, turn_map;
  logic             next_color, busy, game_over, winner, rejected;
  logic [8:0]       move_count;

  omok_board_engine dut (
    .clk(clk), .rst(rst), .cur_pos(cur_pos), .put(put), .undo(undo),
    .board_state(board_state), .turn_map(turn_map), .next_color(next_color),
    .move_count(move_count), .busy(busy), .game_over(game_over),
    .winner(winner), .rejected(rejected)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    int               tgt;
    bit               rej;
    int               mc;
    bit               nc;
    bit               bsy;
    bit               occ;
    bit               col;
    logic [CELLS-1:0] brd;
    logic [CELLS-1:0] trn;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model
  bit   m_occ [CELLS];
  bit   m_col [CELLS];
  int   m_stk [$];
  bit   m_nc, m_go, m_win;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] pack_occ();
    logic [CELLS-1:0] v;
    for (int i = 0; i < CELLS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic logic [CELLS-1:0] pack_col();
    logic [CELLS-1:0] v;
    for (int i = 0; i < CELLS; i++) v[i] = m_col[i];
    return v;
  endfunction

  // Longest same-colour line through p in any of the four directions
  function automatic bit m_wins(input int p, input bit c);
    int dr [4];
    int dc [4];
    dr[0] = 0; dc[0] = 1;
    dr[1] = 1; dc[1] = 0;
    dr[2] = 1; dc[2] = 1;
    dr[3] = 1; dc[3] = -1;
    for (int d = 0; d < 4; d++) begin
      int cnt = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int r = p / N + s * dr[d];
        int q = p % N + s * dc[d];
        while (r >= 0 && r < N && q >= 0 && q < N && m_occ[r*N+q] && m_col[r*N+q] == c) begin
          cnt++;
          r += s * dr[d];
          q += s * dc[d];
        end
      end
      if (cnt >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; put = 1'b0; undo = 1'b0; cur_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_occ = '{default: 1'b0};
    m_col = '{default: 1'b0};
    m_stk.delete();
    m_nc = 1'b0; m_go = 1'b0; m_win = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":board"}, board_state, '0);
    check({tag, ":turn"},  turn_map, '0);
    check({tag, ":mc"},    move_count, 0);
    check({tag, ":nc"},    next_color, 0);
    check({tag, ":busy"},  busy, 0);
    check({tag, ":go"},    game_over, 0);
    check({tag, ":win"},   winner, 0);
    check({tag, ":rej"},   rejected, 0);
  endtask

  task automatic wait_idle(input string tag, input int start);
    int cyc = start;
    while (busy === 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":scan_end"}, busy, 0);
    check({tag, ":scan_len"}, (cyc <= 34), 1);
  endtask

  // One put/undo request (in IDLE): model predicts, scoreboard holds, DUT compared
  task automatic do_req(input string tag, input bit p, input bit u, input int pos);
    exp_t e;
    bit   placed = 1'b0;
    bit   colr   = 1'b0;
    e.tag = tag; e.tgt = -1; e.rej = 1'b0; e.bsy = 1'b0;
    if (u) begin
      if (m_stk.size() > 0) begin
        int t = m_stk.pop_back();
        m_occ[t] = 1'b0; m_col[t] = 1'b0;
        m_nc = !m_nc; m_go = 1'b0; m_win = 1'b0;
        e.tgt = t;
      end else e.rej = 1'b1;
    end else if (p) begin
      if (!m_go && pos < CELLS && !m_occ[pos] && m_stk.size() < 100) begin
        m_occ[pos] = 1'b1; m_col[pos] = m_nc; m_stk.push_back(pos);
        colr = m_nc; m_nc = !m_nc;
        e.tgt = pos; e.bsy = 1'b1; placed = 1'b1;
      end else e.rej = 1'b1;
    end
    e.mc = m_stk.size(); e.nc = m_nc;
    e.occ = (e.tgt >= 0) ? m_occ[e.tgt] : 1'b0;
    e.col = (e.tgt >= 0) ? m_col[e.tgt] : 1'b0;
    e.brd = pack_occ(); e.trn = pack_col();
    sb.push_back(e);

    cur_pos = pos[7:0]; put = p; undo = u;
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.tag, ":rej"},   rejected, e.rej);
    check({e.tag, ":mc"},    move_count, e.mc);
    check({e.tag, ":nc"},    next_color, e.nc);
    check({e.tag, ":busy"},  busy, e.bsy);
    check({e.tag, ":board"}, board_state, e.brd);
    check({e.tag, ":turn"},  turn_map, e.trn);
    if (e.tgt >= 0) begin
      check({e.tag, ":cell"}, board_state[e.tgt], e.occ);
      check({e.tag, ":colr"}, turn_map[e.tgt], e.col);
    end
    put = 1'b0; undo = 1'b0;
    @(posedge clk); #1;
    check({e.tag, ":pulse"}, rejected, 0);
    if (placed) begin
      wait_idle(e.tag, 2);
      m_go  = m_wins(pos, colr);
      m_win = colr;
    end
    check({e.tag, ":go"}, game_over, m_go);
    if (m_go) check({e.tag, ":winner"}, winner, m_win);
  endtask

  task automatic play(input string tag, input int mv [9]);
    for (int i = 0; i < 9; i++) do_req($sformatf("%s%0d", tag, i), 1'b1, 1'b0, mv[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_dut();
    check_zero("reset");

    // Single stone, re-put on occupied cell, out-of-range cell
    do_req("p44", 1'b1, 1'b0, 44);
    check("p44_go", game_over, 0);
    do_req("p44_again", 1'b1, 1'b0, 44);
    check("p44_again_mc", move_count, 1);
    do_req("p100", 1'b1, 1'b0, 100);

    // Horizontal black win on row 4
    reset_dut();
    play("h", '{40, 50, 41, 51, 42, 52, 43, 53, 44});
    check("h_win_go", game_over, 1);
    check("h_win_colour", winner, 0);
    do_req("after_win", 1'b1, 1'b0, 60);

    // Undo back to an empty board, then one more undo
    do_req("undo_win", 1'b0, 1'b1, 0);
    check("undo_win_mc", move_count, 8);
    check("undo_win_44", board_state[44], 0);
    for (int i = 0; i < 9; i++) do_req($sformatf("undo%0d", i), 1'b0, 1'b1, 0);
    check("undo_empty", board_state, '0);
    do_req("undo_extra", 1'b0, 1'b1, 0);

    // Put and undo edges together: only undo applies
    do_req("s11", 1'b1, 1'b0, 11);
    do_req("s22", 1'b1, 1'b0, 22);
    do_req("s33", 1'b1, 1'b0, 33);
    do_req("both", 1'b1, 1'b1, 55);
    check("both_mc", move_count, 2);

    // Put edge while busy is dropped silently
    m_occ[55] = 1'b1; m_col[55] = m_nc; m_stk.push_back(55); m_nc = !m_nc;
    cur_pos = 8'd55; put = 1'b1;
    @(posedge clk); #1;
    check("bz_busy", busy, 1);
    check("bz_cell", board_state[55], 1);
    put = 1'b0;
    @(posedge clk); #1;
    cur_pos = 8'd66; put = 1'b1;
    @(posedge clk); #1;
    check("bz_rej", rejected, 0);
    check("bz_mc", move_count, 3);
    put = 1'b0;
    @(posedge clk); #1;
    check("bz_rej2", rejected, 0);
    wait_idle("bz", 4);
    check("bz_board", board_state, pack_occ());
    check("bz_turn", turn_map, pack_col());
    check("bz_66", board_state[66], 0);
    check("bz_go", game_over, 0);

    // Row-wrap traps: no wins across a row boundary
    reset_dut();
    play("wrap", '{6, 90, 7, 91, 8, 92, 9, 94, 10});
    check("wrap_nowin", game_over, 0);
    reset_dut();
    play("trap", '{9, 90, 19, 91, 29, 92, 39, 94, 0});
    check("trap_nowin", game_over, 0);
    do_req("trap_w", 1'b1, 1'b0, 95);
    do_req("trap_v", 1'b1, 1'b0, 49);
    check("vert_win_go", game_over, 1);

    // Diagonal, anti-diagonal, and a white win
    reset_dut();
    play("dg", '{0, 90, 11, 91, 22, 92, 33, 94, 44});
    check("diag_win_go", game_over, 1);
    reset_dut();
    play("ad", '{4, 90, 13, 91, 22, 92, 31, 94, 40});
    check("anti_win_go", game_over, 1);
    reset_dut();
    play("ww", '{0, 50, 1, 51, 2, 52, 3, 53, 88});
    do_req("ww9", 1'b1, 1'b0, 54);
    check("white_win_go", game_over, 1);
    check("white_win_colour", winner, 1);

    // Reset in the middle of a scan
    reset_dut();
    cur_pos = 8'd44; put = 1'b1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    put = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_rst");
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
